// File: rtl/switch_rdram_arb.sv
// switch_rdram_arb: N-client read-port arbiter for a single-port read RAM (i_sel or round-robin), returns tagged read data to the owning client
module switch_rdram_arb #(
  parameter int DWIDTH = 16,
  parameter int RAM_DEPTH = 3072,
  parameter int NCLIENTS = 2,
  parameter int RD_LATENCY = 1,
  parameter int MODE = 0,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int CW = $clog2(NCLIENTS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [CW-1:0]                i_sel,
  input  logic [NCLIENTS-1:0]          i_req,
  input  logic [NCLIENTS*AW-1:0]       i_client_addr,
  output logic [NCLIENTS-1:0]          o_gnt,
  output logic [NCLIENTS*DWIDTH-1:0]   o_client_data,
  output logic [NCLIENTS-1:0]          o_client_valid,
  output logic [AW-1:0]                o_ram_addr,
  output logic                         o_ram_en,
  input  logic [DWIDTH-1:0]            i_ram_data
);
  logic [CW-1:0] ptr, gidx, out_i;
  logic hit, out_v;
  logic tag_v [RD_LATENCY];
  logic [CW-1:0] tag_i [RD_LATENCY];
  assign out_v = tag_v[RD_LATENCY-1];
  assign out_i = tag_i[RD_LATENCY-1];
  always_comb begin
    hit = 1'b0;
    gidx = '0;
    if (MODE == 0) begin
      hit = !i_rst && ({1'b0, i_sel} < (CW+1)'(NCLIENTS)) && i_req[i_sel];
      gidx = i_sel;
    end else
      // descending scan so the nearest requester after ptr is the last writer
      for (int k = NCLIENTS; k >= 1; k--)
        if (!i_rst && i_req[(int'(ptr) + k) % NCLIENTS]) begin
          hit = 1'b1;
          gidx = CW'((int'(ptr) + k) % NCLIENTS);
        end
    for (int k = 0; k < NCLIENTS; k++) o_gnt[k] = hit && gidx == CW'(k);
    o_ram_en = hit;
    o_ram_addr = hit ? i_client_addr[int'(gidx)*AW +: AW] : '0;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      ptr <= CW'(NCLIENTS-1);
      o_client_data <= '0;
      o_client_valid <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_v[k] <= 1'b0;
        tag_i[k] <= '0;
      end
    end else begin
      if (hit) ptr <= gidx;
      tag_v[0] <= hit;
      tag_i[0] <= gidx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_i[k] <= tag_i[k-1];
      end
      for (int k = 0; k < NCLIENTS; k++) begin
        o_client_valid[k] <= out_v && out_i == CW'(k);
        if (out_v && out_i == CW'(k)) o_client_data[k*DWIDTH +: DWIDTH] <= i_ram_data;
      end
    end
endmodule

// File: tb/tb_switch_rdram_arb.sv
// tb_switch_rdram_arb: directed checks of select-mode, round-robin and long-latency arbiter instances
module tb_switch_rdram_arb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [0:0] sel0; logic [1:0] req0, gnt0, val0; logic [23:0] addr0; logic [31:0] data0;
  logic [11:0] raddr0; logic en0; logic [15:0] rdata0;
  logic [1:0] sel1; logic [3:0] req1, gnt1, val1; logic [47:0] addr1; logic [63:0] data1;
  logic [11:0] raddr1; logic en1; logic [15:0] rdata1;
  logic [1:0] sel2; logic [2:0] req2, gnt2, val2; logic [35:0] addr2; logic [47:0] data2;
  logic [11:0] raddr2; logic en2; logic [15:0] rdata2, q2a, q2b;
  switch_rdram_arb #(.DWIDTH(16), .RAM_DEPTH(3072), .NCLIENTS(2), .RD_LATENCY(1), .MODE(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel0), .i_req(req0), .i_client_addr(addr0), .o_gnt(gnt0),
    .o_client_data(data0), .o_client_valid(val0), .o_ram_addr(raddr0), .o_ram_en(en0), .i_ram_data(rdata0));
  switch_rdram_arb #(.DWIDTH(16), .RAM_DEPTH(3072), .NCLIENTS(4), .RD_LATENCY(1), .MODE(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel1), .i_req(req1), .i_client_addr(addr1), .o_gnt(gnt1),
    .o_client_data(data1), .o_client_valid(val1), .o_ram_addr(raddr1), .o_ram_en(en1), .i_ram_data(rdata1));
  switch_rdram_arb #(.DWIDTH(16), .RAM_DEPTH(3072), .NCLIENTS(3), .RD_LATENCY(3), .MODE(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel2), .i_req(req2), .i_client_addr(addr2), .o_gnt(gnt2),
    .o_client_data(data2), .o_client_valid(val2), .o_ram_addr(raddr2), .o_ram_en(en2), .i_ram_data(rdata2));
  function automatic logic [15:0] ramw(input logic [11:0] a);
    return a == 12'd5 ? 16'hABCD : {4'hC, a};
  endfunction
  always @(posedge clk) begin
    rdata0 <= ramw(raddr0);
    rdata1 <= ramw(raddr1);
    q2a <= ramw(raddr2);
    q2b <= q2a;
    rdata2 <= q2b;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    sel0 = 1'b1; req0 = 2'b11; sel1 = 2'd0; req1 = 4'hF; sel2 = 2'd0; req2 = 3'b111;
    addr0 = {12'd5, 12'd7}; addr1 = {12'h103, 12'h102, 12'h101, 12'h100}; addr2 = {12'h202, 12'h201, 12'h200};
    #1;
    total++; if ({gnt0, gnt1, gnt2} !== 9'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", {gnt0, gnt1, gnt2}); end
    total++; if ({en0, en1, en2} !== 3'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", {en0, en1, en2}); end
    total++; if ({raddr0, raddr1, raddr2} !== 36'b0) begin bad++; $display("FAIL reset_addr got=%h exp=0", {raddr0, raddr1, raddr2}); end
    total++; if ({val0, val1, val2} !== 9'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", {val0, val1, val2}); end
    total++; if ({data0, data1, data2} !== 144'b0) begin bad++; $display("FAIL reset_data got=%h exp=0", {data0, data1, data2}); end
    tick; tick;
    req0 = '0; req1 = '0; req2 = '0; rst = 1'b0;
    tick;
  endtask
  task automatic test_mode0;
    sel0 = 1'b0; req0 = 2'b10;
    #1;
    total++; if ({gnt0, en0} !== 3'b000) begin bad++; $display("FAIL m0_unsel got=%b exp=000", {gnt0, en0}); end
    sel0 = 1'b1; req0 = 2'b11;
    #1;
    total++; if (gnt0 !== 2'b10) begin bad++; $display("FAIL m0_gnt got=%b exp=10", gnt0); end
    total++; if ({en0, raddr0} !== {1'b1, 12'd5}) begin bad++; $display("FAIL m0_ram got=%b/%h exp=1/005", en0, raddr0); end
    tick;
    req0 = 2'b00;
    #1;
    total++; if (val0 !== 2'b00) begin bad++; $display("FAIL m0_early_valid got=%b exp=00", val0); end
    tick;
    total++; if (val0 !== 2'b10) begin bad++; $display("FAIL m0_valid got=%b exp=10", val0); end
    total++; if (data0 !== 32'hABCD_0000) begin bad++; $display("FAIL m0_data got=%h exp=abcd0000", data0); end
    tick;
    total++; if (val0 !== 2'b00) begin bad++; $display("FAIL m0_pulse got=%b exp=00", val0); end
    total++; if (data0 !== 32'hABCD_0000) begin bad++; $display("FAIL m0_hold got=%h exp=abcd0000", data0); end
  endtask
  task automatic test_rr_all;
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 10; i++) begin
      req1 = i < 8 ? 4'hF : 4'h0;
      #1;
      if (i < 8) begin
        total++; if (gnt1 !== 4'(1 << order[i])) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt1, 4'(1 << order[i])); end
        total++; if ({en1, raddr1} !== {1'b1, 12'h100 + 12'(order[i])}) begin bad++; $display("FAIL rr_ram[%0d] got=%b/%h exp=1/%h", i, en1, raddr1, 12'h100 + 12'(order[i])); end
      end
      if (i < 2) begin
        total++; if (val1 !== 4'b0) begin bad++; $display("FAIL rr_val[%0d] got=%b exp=0000", i, val1); end
      end else begin
        total++; if (val1 !== 4'(1 << order[i-2])) begin bad++; $display("FAIL rr_val[%0d] got=%b exp=%b", i, val1, 4'(1 << order[i-2])); end
        total++; if (data1[order[i-2]*16 +: 16] !== 16'hC100 + 16'(order[i-2])) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, data1[order[i-2]*16 +: 16], 16'hC100 + 16'(order[i-2])); end
      end
      tick;
    end
  endtask
  task automatic test_rr_partial;
    int p[7] = '{1, 3, 1, 3, 3, 3, 3};
    for (int i = 0; i < 7; i++) begin
      req1 = i < 4 ? 4'b1010 : 4'b1000;
      #1;
      total++; if (gnt1 !== 4'(1 << p[i])) begin bad++; $display("FAIL rrp_gnt[%0d] got=%b exp=%b", i, gnt1, 4'(1 << p[i])); end
      tick;
    end
    req1 = '0;
    tick; tick;
  endtask
  task automatic test_latency3;
    int s[3] = '{2, 0, 2};
    for (int i = 0; i < 8; i++) begin
      req2 = i < 3 ? 3'b111 : 3'b000;
      sel2 = i < 3 ? 2'(s[i]) : 2'd0;
      addr2 = {(i == 2 ? 12'h20A : 12'h202), 12'h201, 12'h200};
      #1;
      if (i < 3) begin
        total++; if (gnt2 !== 3'(1 << s[i])) begin bad++; $display("FAIL l3_gnt[%0d] got=%b exp=%b", i, gnt2, 3'(1 << s[i])); end
      end
      if (i >= 4 && i <= 6) begin
        total++; if (val2 !== 3'(1 << s[i-4])) begin bad++; $display("FAIL l3_val[%0d] got=%b exp=%b", i, val2, 3'(1 << s[i-4])); end
      end else begin
        total++; if (val2 !== 3'b0) begin bad++; $display("FAIL l3_val[%0d] got=%b exp=000", i, val2); end
      end
      if (i == 4) begin
        total++; if (data2[47:32] !== 16'hC202) begin bad++; $display("FAIL l3_data2a got=%h exp=c202", data2[47:32]); end
      end
      if (i == 5) begin
        total++; if (data2[15:0] !== 16'hC200) begin bad++; $display("FAIL l3_data0 got=%h exp=c200", data2[15:0]); end
      end
      if (i == 6) begin
        total++; if (data2[47:32] !== 16'hC20A) begin bad++; $display("FAIL l3_data2b got=%h exp=c20a", data2[47:32]); end
      end
      tick;
    end
  endtask
  task automatic test_sel_oob;
    sel2 = 2'd3; req2 = 3'b111;
    #1;
    total++; if ({gnt2, en2, raddr2} !== 16'b0) begin bad++; $display("FAIL oob got=%b/%b/%h exp=0/0/000", gnt2, en2, raddr2); end
    sel2 = 2'd1; req2 = 3'b010;
    #1;
    total++; if ({gnt2, en2, raddr2} !== {3'b010, 1'b1, 12'h201}) begin bad++; $display("FAIL sel1 got=%b/%b/%h exp=010/1/201", gnt2, en2, raddr2); end
    tick;
    req2 = '0;
    tick; tick; tick;
    total++; if (val2 !== 3'b010) begin bad++; $display("FAIL sel1_val got=%b exp=010", val2); end
    total++; if (data2[31:16] !== 16'hC201) begin bad++; $display("FAIL sel1_data got=%h exp=c201", data2[31:16]); end
    tick;
  endtask
  task automatic test_reset_mid;
    sel0 = 1'b1; req0 = 2'b11; req1 = 4'hF; sel2 = 2'd0; req2 = 3'b111;
    tick; tick;
    rst = 1'b1;
    #1;
    total++; if ({gnt0, gnt1, gnt2, en0, en1, en2} !== 12'b0) begin bad++; $display("FAIL mid_gnt got=%b exp=0", {gnt0, gnt1, gnt2, en0, en1, en2}); end
    total++; if ({val0, val1, val2} !== 9'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", {val0, val1, val2}); end
    total++; if (data1 !== 64'b0) begin bad++; $display("FAIL mid_data got=%h exp=0", data1); end
    tick;
    rst = 1'b0; req0 = '0; req1 = '0; req2 = '0;
    for (int i = 0; i < 6; i++) begin
      tick;
      total++; if ({val0, val1, val2} !== 9'b0) begin bad++; $display("FAIL stale_valid[%0d] got=%b exp=0", i, {val0, val1, val2}); end
    end
  endtask
  initial begin
    test_reset;
    test_mode0;
    test_rr_all;
    test_rr_partial;
    test_latency3;
    test_sel_oob;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
